// File: rtl/lif_spike_arbiter.sv
// Round-robin AER serialiser for LIF spike pulses: one pending event per neuron, sticky overflow and drop counter.
// Define LIF_ARB_TIMESTAMP_EN to attach a capture timestamp (ev_ts) to every event.
module lif_spike_arbiter #(
    parameter int N_NEURONS = 8,
    parameter int ADDR_W    = 3,
    parameter int TS_W      = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic [N_NEURONS-1:0] spike_in,
    output logic                 ev_valid,
    input  logic                 ev_ready,
    output logic [ADDR_W-1:0]    ev_addr,
    output logic [TS_W-1:0]      ev_ts,
    output logic                 busy,
    output logic                 overflow,
    output logic [7:0]           drop_count
);

    logic [N_NEURONS-1:0] pending;
    logic [ADDR_W-1:0]    rr_ptr;

    logic                 slot_free;
    logic                 grant;
    logic [ADDR_W-1:0]    sel;
    logic [ADDR_W-1:0]    rr_next;
    logic [N_NEURONS-1:0] grant_mask;
    logic [N_NEURONS-1:0] capture;
    logic [N_NEURONS-1:0] drops;
    logic [N_NEURONS-1:0] set_mask;
    logic [N_NEURONS-1:0] pending_next;
    logic [6:0]           n_drops;
    logic [9:0]           drop_sum;
    logic [7:0]           drop_next;

    // First requester at or after ptr, wrapping at N_NEURONS (not at 2**ADDR_W).
    function automatic logic [ADDR_W-1:0] rr_pick(input logic [N_NEURONS-1:0] req,
                                                 input logic [ADDR_W-1:0] ptr);
        logic [ADDR_W-1:0] pick;
        logic              found;
        int                idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < N_NEURONS; k++) begin
            idx = (int'(ptr) + k) % N_NEURONS;
            if (!found && req[idx]) begin
                pick  = ADDR_W'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [6:0] count_ones(input logic [N_NEURONS-1:0] bits);
        logic [6:0] c;
        c = '0;
        for (int i = 0; i < N_NEURONS; i++) begin
            c = c + 7'(bits[i]);
        end
        return c;
    endfunction

    assign slot_free = !ev_valid || ev_ready;
    assign grant     = slot_free && (|pending);
    assign sel       = rr_pick(pending, rr_ptr);
    assign rr_next   = (sel == ADDR_W'(N_NEURONS - 1)) ? '0 : sel + 1'b1;

    // A spike on a bit being granted this cycle re-arms it instead of counting as a drop.
    always_comb begin
        grant_mask   = '0;
        if (grant) begin
            grant_mask = {{(N_NEURONS-1){1'b0}}, 1'b1} << sel;
        end
        capture      = en ? spike_in : '0;
        drops        = capture & pending & ~grant_mask;
        set_mask     = capture & ~drops;
        pending_next = (pending & ~grant_mask) | capture;
        n_drops      = count_ones(drops);
        drop_sum     = {2'b00, drop_count} + {3'b000, n_drops};
        drop_next    = (drop_sum > 10'd255) ? 8'd255 : drop_sum[7:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending    <= '0;
            rr_ptr     <= '0;
            ev_valid   <= 1'b0;
            ev_addr    <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            pending <= pending_next;
            if (slot_free) begin
                ev_valid <= grant;
                if (grant) begin
                    ev_addr <= sel;
                    rr_ptr  <= rr_next;
                end
            end
            if (|drops) begin
                overflow   <= 1'b1;
                drop_count <= drop_next;
            end
        end
    end

    assign busy = (|pending) || ev_valid;

`ifdef LIF_ARB_TIMESTAMP_EN
    logic [TS_W-1:0] ts_counter;
    logic [TS_W-1:0] ts_store [N_NEURONS];

    // The stamp reflects the counter during the cycle the spike was presented.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ts_counter <= '0;
            ev_ts      <= '0;
            for (int i = 0; i < N_NEURONS; i++) begin
                ts_store[i] <= '0;
            end
        end else begin
            ts_counter <= ts_counter + 1'b1;
            for (int i = 0; i < N_NEURONS; i++) begin
                if (set_mask[i]) begin
                    ts_store[i] <= ts_counter;
                end
            end
            if (grant) begin
                ev_ts <= ts_store[sel];
            end
        end
    end
`else
    logic unused_set_mask;
    assign unused_set_mask = ^set_mask;
    assign ev_ts           = '0;
`endif

endmodule

// File: tb/tb_lif_spike_arbiter.sv
// Directed bench for lif_spike_arbiter with a queue scoreboard of expected AER events.
// Timestamp checks are compiled in when LIF_ARB_TIMESTAMP_EN is defined.
module tb_lif_spike_arbiter;

    localparam int N  = 8;
    localparam int AW = 3;
    localparam int TW = 4;

    logic          clk;
    logic          reset;
    logic          en;
    logic [N-1:0]  spike_in;
    logic          ev_valid;
    logic          ev_ready;
    logic [AW-1:0] ev_addr;
    logic [TW-1:0] ev_ts;
    logic          busy;
    logic          overflow;
    logic [7:0]    drop_count;

    typedef struct {
        logic [AW-1:0] addr;
        logic [TW-1:0] ts;
        bit            chk_ts;
    } ev_t;

    ev_t sb[$];
    int  errors = 0;
    int  checks = 0;

    lif_spike_arbiter #(.N_NEURONS(N), .ADDR_W(AW), .TS_W(TW)) dut (
        .clk(clk), .reset(reset), .en(en), .spike_in(spike_in),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_addr(ev_addr), .ev_ts(ev_ts),
        .busy(busy), .overflow(overflow), .drop_count(drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_ev(input logic [AW-1:0] addr, input logic [TW-1:0] ts, input bit chk_ts);
        ev_t e;
        e.addr   = addr;
        e.ts     = ts;
        e.chk_ts = chk_ts;
        sb.push_back(e);
    endtask

    task automatic reset_dut();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && sb.size() != 0; i++) step();
        check_output("drain_empty", sb.size(), 0);
        step();
        check_output("idle_valid", ev_valid, 0);
        check_output("idle_busy", busy, 0);
    endtask

    // Handshake is decided at the next rising edge; inputs only change just after rising edges.
    always @(negedge clk) begin
        if (reset && ev_valid && ev_ready) begin
            check_output("sb_nonempty", (sb.size() > 0), 1);
            if (sb.size() > 0) begin
                ev_t e;
                e = sb.pop_front();
                check_output("ev_addr", ev_addr, e.addr);
`ifdef LIF_ARB_TIMESTAMP_EN
                if (e.chk_ts) check_output("ev_ts", ev_ts, e.ts);
`else
                check_output("ev_ts_zero", ev_ts, 0);
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset    = 1'b0;
        en       = 1'b0;
        spike_in = '0;
        ev_ready = 1'b0;
        #2;
        check_output("rst_valid", ev_valid, 0);
        check_output("rst_busy", busy, 0);
        check_output("rst_overflow", overflow, 0);
        check_output("rst_drops", drop_count, 0);
        check_output("rst_addr", ev_addr, 0);
        check_output("rst_ts", ev_ts, 0);
        reset_dut();

        // single event, two-edge latency
        en = 1'b1;
        ev_ready = 1'b1;
        spike_in = 8'b0000_0100;
        push_ev(3'd2, '0, 1'b0);
        step();
        spike_in = '0;
        check_output("single_lat1_valid", ev_valid, 0);
        check_output("single_lat1_busy", busy, 1);
        step();
        check_output("single_valid", ev_valid, 1);
        check_output("single_addr", ev_addr, 2);
        step();
        check_output("single_done_valid", ev_valid, 0);
        check_output("single_done_busy", busy, 0);

        // round robin from a fresh pointer
        reset_dut();
        spike_in = 8'hFF;
        for (int i = 0; i < N; i++) push_ev(AW'(i), '0, 1'b0);
        step();
        spike_in = '0;
        step();
        for (int i = 0; i < N; i++) begin
            check_output("rr_valid", ev_valid, 1);
            check_output("rr_addr", ev_addr, i);
            step();
        end
        check_output("rr_end_valid", ev_valid, 0);
        spike_in = 8'b1000_0001;
        push_ev(3'd0, '0, 1'b0);
        push_ev(3'd7, '0, 1'b0);
        step();
        spike_in = '0;
        step();
        check_output("wrap_first", ev_addr, 0);
        step();
        check_output("wrap_second", ev_addr, 7);
        step();
        check_output("wrap_idle", ev_valid, 0);

        // backpressure hold
        ev_ready = 1'b0;
        spike_in = 8'b0001_0010;
        push_ev(3'd1, '0, 1'b0);
        push_ev(3'd4, '0, 1'b0);
        step();
        spike_in = '0;
        step();
        for (int i = 0; i < 10; i++) begin
            check_output("hold_valid", ev_valid, 1);
            check_output("hold_addr", ev_addr, 1);
            step();
        end
        ev_ready = 1'b1;
        step();
        check_output("bp_next_valid", ev_valid, 1);
        check_output("bp_next_addr", ev_addr, 4);
        step();
        check_output("bp_idle", ev_valid, 0);

        // drop and saturation: slot holds neuron 0, neuron 3 pends and keeps spiking
        ev_ready = 1'b0;
        spike_in = 8'b0000_0001;
        push_ev(3'd0, '0, 1'b0);
        push_ev(3'd3, '0, 1'b0);
        step();
        spike_in = '0;
        step();
        check_output("drop_slot_addr", ev_addr, 0);
        spike_in = 8'b0000_1000;
        step();
        check_output("drop_first_none", drop_count, 0);
        check_output("drop_first_ovf", overflow, 0);
        repeat (10) step();
        check_output("drop_count_10", drop_count, 10);
        check_output("drop_ovf_set", overflow, 1);
        repeat (289) step();
        spike_in = '0;
        check_output("drop_sat", drop_count, 255);
        step();
        check_output("drop_sat_hold", drop_count, 255);
        check_output("drop_ovf_sticky", overflow, 1);
        ev_ready = 1'b1;
        drain();
        check_output("drop_after_drain", drop_count, 255);

        // re-spike on the grant cycle is a new event, not a drop
        reset_dut();
        spike_in = 8'b0010_0000;
        push_ev(3'd5, '0, 1'b0);
        push_ev(3'd5, '0, 1'b0);
        step();
        step();
        spike_in = '0;
        step();
        check_output("respike_addr", ev_addr, 5);
        check_output("respike_valid", ev_valid, 1);
        drain();
        check_output("respike_drops", drop_count, 0);
        check_output("respike_ovf", overflow, 0);

        // en=0 ignores spikes while events still drain
        ev_ready = 1'b0;
        spike_in = 8'b0000_0100;
        push_ev(3'd2, '0, 1'b0);
        push_ev(3'd2, '0, 1'b0);
        step();
        spike_in = '0;
        step();
        spike_in = 8'b0000_0100;
        step();
        en = 1'b0;
        spike_in = 8'hFF;
        repeat (5) step();
        spike_in = '0;
        en = 1'b1;
        check_output("en0_drops", drop_count, 0);
        check_output("en0_ovf", overflow, 0);
        check_output("en0_busy", busy, 1);
        check_output("en0_addr", ev_addr, 2);
        ev_ready = 1'b1;
        drain();

        // asynchronous reset while an event is held
        ev_ready = 1'b0;
        spike_in = 8'b0000_0010;
        step();
        spike_in = '0;
        step();
        check_output("pre_rst_valid", ev_valid, 1);
        #3;
        reset = 1'b0;
        #1;
        check_output("async_rst_valid", ev_valid, 0);
        check_output("async_rst_busy", busy, 0);
        check_output("async_rst_addr", ev_addr, 0);
        step();
        reset = 1'b1;

`ifdef LIF_ARB_TIMESTAMP_EN
        // counter reads 0 right after release, so 14 edges later it reads 14
        reset_dut();
        ev_ready = 1'b1;
        repeat (14) step();
        spike_in = 8'b0100_0000;
        push_ev(3'd6, 4'd14, 1'b1);
        step();
        spike_in = '0;
        step();
        check_output("ts_first", ev_ts, 14);
        step();
        spike_in = 8'b0100_0000;
        push_ev(3'd6, 4'd1, 1'b1);
        step();
        spike_in = '0;
        step();
        check_output("ts_wrap", ev_ts, 1);
        drain();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lif_spike_arbiter.md
Name: lif_spike_arbiter

Overview:
- Collects spike pulses from N_NEURONS LIF neuron instances and serialises them into one address-event (AER) stream.
- Uses round-robin arbitration and a valid/ready handshake.
- Sits between the neuron array and the downstream motor-pattern / host link.
- Holds one pending event per neuron and counts spikes lost to overflow.

Parameters:
- N_NEURONS, 8, number of spike inputs (2..64).
- ADDR_W, 3, event address width; must satisfy 2**ADDR_W >= N_NEURONS.
- TS_W, 16, timestamp width (used only with LIF_ARB_TIMESTAMP_EN).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- en  input  1  capture enable; 0 = ignore spike_in, keep draining pending events.
- spike_in  input  N_NEURONS  one-cycle spike pulses, bit i = neuron i.
- ev_valid  output  1  event present on ev_addr.
- ev_ready  input  1  downstream accepts event when ev_valid & ev_ready at clk edge.
- ev_addr  output  ADDR_W  index of spiking neuron.
- ev_ts  output  TS_W  spike capture timestamp (macro only).
- busy  output  1  high when any pending bit set or ev_valid high.
- overflow  output  1  sticky; set on first dropped spike.
- drop_count  output  8  dropped spike count, saturates at 255.

Behaviour:
- Reset (reset=0, async): pending=0, rr_ptr=0, ev_valid=0, ev_addr=0, ev_ts=0, overflow=0, drop_count=0, timestamp counter=0. busy=0.
- Capture: at each edge with en=1, pending[i] is set for every spike_in[i]=1. With en=0, spike_in is ignored and never counted as a drop.
- Output slot: a single register. It is "free" when ev_valid=0, or when ev_valid=1 and ev_ready=1 (back-to-back transfer, 1 event/cycle maximum).
- Grant, when the slot is free and pending != 0:
  - sel = first set pending index searching from rr_ptr upward, wrapping past N_NEURONS-1 to 0.
  - Load ev_addr=sel and ev_valid=1, clear pending[sel], set rr_ptr=(sel+1) mod N_NEURONS.
- Slot free and pending == 0: ev_valid goes to 0 (only after a handshake).
- Hold rule: while ev_valid=1 and ev_ready=0, ev_addr and ev_ts stay stable and rr_ptr does not move.
- Latency: spike_in high in cycle 0 gives pending set after edge 1 and ev_valid=1 after edge 2, if the slot is free. No combinational path from spike_in or ev_ready to the outputs.
- Simultaneous spike and grant: if spike_in[i]=1 in the same cycle that pending[i] is granted, pending[i] is set again (new event, not a drop).
- Drop: spike_in[i]=1, en=1, pending[i]=1 and i is not granted that cycle. The new spike is discarded and the existing pending event is kept.
  - drop_count increments by the number of dropped bits that cycle, saturating at 255.
  - overflow is set and stays set until reset.
- busy = |pending | ev_valid (registered state only).
- Reset mid-transfer: outputs clear immediately; in-flight and pending events are lost.

Optional Feature:
- Macro: LIF_ARB_TIMESTAMP_EN.
- Defined:
  - A free-running TS_W counter increments every clk edge and wraps from 2**TS_W-1 to 0.
  - A per-neuron timestamp register captures the counter value on the edge that sets pending[i]. This includes the re-set on a simultaneous grant; a dropped spike does not overwrite it.
  - ev_ts is loaded with ts[sel] together with ev_addr.
- Not defined:
  - Counter and timestamp storage are absent; ev_ts is tied to 0.
  - All other behaviour is unchanged.

Test Plan:
- Single event: reset, en=1, ev_ready=1, pulse spike_in=8'b0000_0100 for one cycle -> ev_valid=1 with ev_addr=2 exactly 2 edges later, for 1 cycle; busy returns to 0.
- Round robin: ev_ready=1, pulse spike_in=8'hFF once -> ev_addr sequence 0,1,...,7 on 8 consecutive cycles. Then pulse 8'b1000_0001 -> order 0,7 (rr_ptr wrapped to 0).
- Backpressure: ev_ready=0, pulse 8'b0001_0010 -> ev_valid held with ev_addr=1 stable for 10 cycles. Raise ev_ready -> 1 then 4 on consecutive cycles.
- Drop/saturation: ev_ready=0, spike_in[3] high continuously for 300 cycles -> overflow=1 and drop_count=255. Release ev_ready -> exactly one event with ev_addr=3.
- Simultaneous grant and re-spike: pending only bit 5, spike_in[5] pulsed on the grant cycle -> two events addr=5, drop_count=0. en=0 with spike_in=8'hFF -> no new events, drop_count unchanged.
- Timestamp (with LIF_ARB_TIMESTAMP_EN, TS_W=4):
  - Spike neuron 6 when the counter is 14 -> ev_ts=14.
  - Spike neuron 6 again 3 cycles later -> ev_ts=1 (wrap).
  - Async reset mid-hold -> ev_valid=0 immediately.
